// File: rtl/mux_scan_pkg.sv
// Shared types for the scanning channel selector: operating modes and the
// decode from the raw 2-bit mode input.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        SCAN   = 2'b01,
        HOLD   = 2'b10
    } mode_e;

    // The reserved encoding 2'b11 is treated as a freeze.
    function automatic mode_e decode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b00:   r = MANUAL;
            2'b01:   r = SCAN;
            default: r = HOLD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for the scan mode: counts 0..TICKS-1 while enabled and flags
// the terminal count combinationally so the owner can advance on that edge.
module scan_timer #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CW = $clog2(TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tc    = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered NCH-way W-bit selector with manual, timed round-robin scan and
// freeze modes; reports the active channel and strobes on every change.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter  int unsigned W     = 2,
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned TICKS = 4,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic [NCH*W-1:0]  din,
    input  logic [SELW-1:0]   sel,
    input  logic [1:0]        mode,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   ch,
    output logic              ch_strobe
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    mode_e           st_q, st_d, eff;
    logic            live_q;
    logic [SELW-1:0] ch_q, ch_d;
    logic [W-1:0]    dout_q, dout_d, dsel;
    logic            strobe_q, strobe_d;
    logic            scan_en, scan_clr, tc;

    // The first edge after reset release is forced to freeze so no output
    // moves on it; st still captures the requested mode on that edge.
    always_comb begin
        st_d     = decode(mode);
        eff      = live_q ? st_d : HOLD;
        scan_en  = (eff == SCAN) && (st_q == SCAN);
        scan_clr = (eff == MANUAL) || ((eff == SCAN) && (st_q != SCAN));
    end

    scan_timer #(
        .TICKS (TICKS)
    ) u_scan_timer (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .en      (scan_en),
        .clr     (scan_clr),
        .tc      (tc)
    );

    always_comb begin
        ch_d = ch_q;
        unique case (eff)
            MANUAL: begin
                if (32'(sel) < NCH) begin
                    ch_d = sel;
                end
            end
            SCAN: begin
                if (tc) begin
                    ch_d = (ch_q == LAST_CH) ? '0 : ch_q + SELW'(1);
                end
            end
            HOLD: begin
                ch_d = ch_q;
            end
            default: begin
                ch_d = ch_q;
            end
        endcase
    end

    always_comb begin
        dsel = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (32'(ch_d) == k) begin
                dsel = din[k*W +: W];
            end
        end
        dout_d   = (eff == HOLD) ? dout_q : dsel;
        strobe_d = (ch_d != ch_q);
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            st_q     <= HOLD;
            live_q   <= 1'b0;
            ch_q     <= '0;
            dout_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            live_q   <= 1'b1;
            ch_q     <= ch_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
        end
    end

    assign dout      = dout_q;
    assign ch        = ch_q;
    assign ch_strobe = strobe_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: a 4-channel/TICKS=3 build and a 6-channel/TICKS=1
// build checked every cycle against a behavioural model, plus directed checks.
module tb_mux_scan_sel;

    logic        clk_2 = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [7:0]  din4;
    logic [1:0]  sel4;
    logic [11:0] din6;
    logic [2:0]  sel6;

    logic [1:0] dout4, ch4;
    logic       stb4;
    logic [1:0] dout6;
    logic [2:0] ch6;
    logic       stb6;

    int total = 0;
    int bad   = 0;

    always #5 clk_2 = ~clk_2;

    mux_scan_sel #(.W(2), .NCH(4), .TICKS(3)) u_dut4 (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .din       (din4),
        .sel       (sel4),
        .mode      (mode),
        .dout      (dout4),
        .ch        (ch4),
        .ch_strobe (stb4)
    );

    mux_scan_sel #(.W(2), .NCH(6), .TICKS(1)) u_dut6 (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .din       (din6),
        .sel       (sel6),
        .mode      (mode),
        .dout      (dout6),
        .ch        (ch6),
        .ch_strobe (stb6)
    );

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] dout;
        logic [7:0] cnt;
        logic [7:0] prev;
        logic       stb;
        logic       live;
    } ms_t;

    ms_t  m4, m6;
    logic chk_en = 1'b0;

    // One clock of the selector from its rules: mode 3 acts as freeze, the
    // first cycle after reset is a freeze, scan dwells TICKS cycles per channel.
    function automatic ms_t step(input ms_t s, input int nch, input int ticks,
                                 input logic [63:0] din, input int sel, input int md,
                                 input bit rn);
        ms_t n;
        int  m, eff, c;
        n = s;
        if (!rn) begin
            n      = '0;
            n.prev = 8'd2;
            return n;
        end
        m   = (md == 3) ? 2 : md;
        eff = s.live ? m : 2;
        c   = int'(s.ch);
        if (eff == 0) begin
            if (sel < nch) c = sel;
            n.cnt = 8'd0;
        end else if (eff == 1) begin
            if (int'(s.prev) != 1) begin
                n.cnt = 8'd0;
            end else if (int'(s.cnt) == ticks - 1) begin
                n.cnt = 8'd0;
                c     = (c + 1) % nch;
            end else begin
                n.cnt = s.cnt + 8'd1;
            end
        end
        n.stb = (c != int'(s.ch));
        if (eff != 2) n.dout = 8'((din >> (c * 2)) & 64'd3);
        n.ch   = 8'(c);
        n.prev = 8'(m);
        n.live = 1'b1;
        return n;
    endfunction

    always @(posedge clk_2) begin
        m4     <= step(m4, 4, 3, {56'd0, din4}, int'(sel4), int'(mode), reset_n);
        m6     <= step(m6, 6, 1, {52'd0, din6}, int'(sel6), int'(mode), reset_n);
        chk_en <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_2) begin
        if (chk_en) begin
            chk("model dout4", 32'(dout4), 32'(m4.dout));
            chk("model ch4",   32'(ch4),   32'(m4.ch));
            chk("model stb4",  32'(stb4),  32'(m4.stb));
            chk("model dout6", 32'(dout6), 32'(m6.dout));
            chk("model ch6",   32'(ch6),   32'(m6.ch));
            chk("model stb6",  32'(stb6),  32'(m6.stb));
        end
    end

    int exp_ch [10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

    initial begin
        reset_n = 1'b0;
        mode    = 2'b01;
        din4    = 8'he4;
        din6    = 12'h4e4;
        sel4    = 2'd0;
        sel6    = 3'd0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk_2);
            chk("reset dout", 32'(dout4), 32'd0);
            chk("reset ch",   32'(ch4),   32'd0);
            chk("reset stb",  32'(stb4),  32'd0);
        end

        reset_n = 1'b1;
        mode    = 2'b10;
        @(negedge clk_2);
        chk("release ch", 32'(ch4), 32'd0);
        chk("release stb", 32'(stb4), 32'd0);

        mode = 2'b00;
        sel4 = 2'd2;
        sel6 = 3'd3;
        @(negedge clk_2);
        chk("manual ch",    32'(ch4),   32'd2);
        chk("manual dout",  32'(dout4), 32'd2);
        chk("manual stb",   32'(stb4),  32'd1);
        chk("manual ch6",   32'(ch6),   32'd3);
        chk("manual dout6", 32'(dout6), 32'd3);
        chk("pin model ch", 32'(m4.ch), 32'd2);
        @(negedge clk_2);
        chk("manual stb once", 32'(stb4), 32'd0);

        for (int i = 6; i < 8; i++) begin
            sel6 = 3'(i);
            @(negedge clk_2);
            chk("oor ch6",  32'(ch6),  32'd3);
            chk("oor stb6", 32'(stb6), 32'd0);
        end

        mode = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_2);
            chk("wrap ch",   32'(ch4),   32'(exp_ch[i]));
            chk("wrap dout", 32'(dout4), 32'(exp_ch[i]));
            chk("wrap stb",  32'(stb4),  32'((i == 3) || (i == 6) || (i == 9)));
        end
        chk("pin model wrap", 32'(m4.ch), 32'd1);

        @(negedge clk_2);
        mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            din4 = 8'($urandom);
            sel4 = 2'($urandom);
            @(negedge clk_2);
            chk("hold ch",   32'(ch4),   32'd1);
            chk("hold dout", 32'(dout4), 32'd1);
        end
        din4 = 8'he4;
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_2);
            chk("rescan ch", 32'(ch4), (i == 3) ? 32'd2 : 32'd1);
        end

        mode = 2'b00;
        sel4 = 2'd1;
        @(negedge clk_2);
        chk("live ch",   32'(ch4),   32'd1);
        chk("live dout", 32'(dout4), 32'd1);
        din4[3:2] = 2'b11;
        @(negedge clk_2);
        chk("live dout new", 32'(dout4), 32'd3);

        mode = 2'b01;
        repeat (3) @(negedge clk_2);
        chk("pre tc ch", 32'(ch4), 32'd1);
        mode = 2'b00;
        sel4 = 2'd0;
        @(negedge clk_2);
        chk("tc jump ch",   32'(ch4),   32'd0);
        chk("tc jump dout", 32'(dout4), 32'd0);
        chk("tc jump stb",  32'(stb4),  32'd1);

        sel4 = 2'd3;
        @(negedge clk_2);
        chk("pre rsv ch", 32'(ch4), 32'd3);
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            din4 = 8'($urandom);
            sel4 = 2'($urandom);
            @(negedge clk_2);
            chk("rsv ch",   32'(ch4),   32'd3);
            chk("rsv dout", 32'(dout4), 32'd3);
            chk("rsv stb",  32'(stb4),  32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            sel4 = 2'($urandom);
            sel6 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) din4 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) din6 = 12'($urandom);
            @(negedge clk_2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
